discrete_values_table_writer: RTL and testbench

DISCRETE_VALUES_TABLE_WRITER -- requirements
Module: discrete_values_table_writer

---
 rtl/discrete_values_table_writer.sv | 130 +++++++++++++
 tb/tb_discrete_values_table_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/discrete_values_table_writer.sv
// rtl/discrete_values_table_writer.sv - loads per-variable {start,end} range tables and serves a registered read port
module discrete_values_table_writer #(
    parameter int BIT_WIDTH_OF_INTEGER_VARIABLE     = 16,
    parameter int DISCRETE_VARIABLE_INDEX_BIT_WIDTH = 2,
    parameter int ENTRY_INDEX_BIT_WIDTH             = 3
) (
    input  logic                                         in_clock,
    input  logic                                         in_reset,
    input  logic                                         in_load_begin,
    input  logic [DISCRETE_VARIABLE_INDEX_BIT_WIDTH-1:0] in_load_variable_index,
    input  logic                                         in_load_valid,
    output logic                                         out_load_ready,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     in_load_start_value,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     in_load_end_value,
    input  logic                                         in_load_last,
    output logic                                         out_load_done,
    output logic                                         out_load_error,
    input  logic [DISCRETE_VARIABLE_INDEX_BIT_WIDTH-1:0] in_read_variable_index,
    input  logic [7:0]                                   in_read_entry_index,
    output logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     out_start,
    output logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     out_end,
    output logic [7:0]                                   out_number_of_discrete_assignments
);

    localparam int NUM_VARIABLES = 1 << DISCRETE_VARIABLE_INDEX_BIT_WIDTH;
    localparam int MAX_ENTRIES   = 1 << ENTRY_INDEX_BIT_WIDTH;
    localparam int COUNT_WIDTH   = ENTRY_INDEX_BIT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_ENTRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                       state;
    logic [DISCRETE_VARIABLE_INDEX_BIT_WIDTH-1:0] load_variable;
    logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     start_table [NUM_VARIABLES][MAX_ENTRIES];
    logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]     end_table   [NUM_VARIABLES][MAX_ENTRIES];
    logic [COUNT_WIDTH-1:0]                       count       [NUM_VARIABLES];

    logic                   beat;
    logic                   range_ok;
    logic                   table_full;
    logic [COUNT_WIDTH-1:0] load_count;
    logic [COUNT_WIDTH-1:0] read_count;
    logic                   read_hit;

    assign load_count = count[load_variable];
    assign beat       = in_load_valid && out_load_ready;
    assign range_ok   = in_load_start_value <= in_load_end_value;
    assign table_full = load_count == MAX_COUNT;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state          <= IDLE;
            load_variable  <= '0;
            out_load_ready <= 1'b0;
            out_load_done  <= 1'b0;
            out_load_error <= 1'b0;
            for (int v = 0; v < NUM_VARIABLES; v++) begin
                count[v] <= '0;
                for (int e = 0; e < MAX_ENTRIES; e++) begin
                    start_table[v][e] <= '0;
                    end_table[v][e]   <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_load_begin) begin
                        load_variable                  <= in_load_variable_index;
                        count[in_load_variable_index]  <= '0;
                        out_load_error                 <= 1'b0;
                        out_load_ready                 <= 1'b1;
                        state                          <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        // Bad or overflowing beats are flagged but the load keeps running to its last beat.
                        if (!range_ok || table_full) begin
                            out_load_error <= 1'b1;
                        end else begin
                            start_table[load_variable][load_count[ENTRY_INDEX_BIT_WIDTH-1:0]] <= in_load_start_value;
                            end_table[load_variable][load_count[ENTRY_INDEX_BIT_WIDTH-1:0]]   <= in_load_end_value;
                            count[load_variable] <= load_count + 1'b1;
                        end
                        if (in_load_last) begin
                            out_load_ready <= 1'b0;
                            out_load_done  <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    out_load_done <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    out_load_ready <= 1'b0;
                    out_load_done  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    assign read_count = count[in_read_variable_index];
    assign read_hit   = in_read_entry_index < 8'(read_count);

    // Reads see the table and count as they were before this edge's write.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_start                          <= '0;
            out_end                            <= '0;
            out_number_of_discrete_assignments <= '0;
        end else begin
            out_number_of_discrete_assignments <= 8'(read_count);
            if (read_hit) begin
                out_start <= start_table[in_read_variable_index][in_read_entry_index[ENTRY_INDEX_BIT_WIDTH-1:0]];
                out_end   <= end_table[in_read_variable_index][in_read_entry_index[ENTRY_INDEX_BIT_WIDTH-1:0]];
            end else begin
                out_start <= '0;
                out_end   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_discrete_values_table_writer.sv
// tb/tb_discrete_values_table_writer.sv - randomized self-checking bench for discrete_values_table_writer
module tb_discrete_values_table_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_begin;
    logic [1:0]  load_var;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_start;
    logic [15:0] load_end;
    logic        load_last;
    logic        load_done;
    logic        load_error;
    logic [1:0]  read_var;
    logic [7:0]  read_entry;
    logic [15:0] rd_start;
    logic [15:0] rd_end;
    logic [7:0]  rd_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] e;
    } range_t;

    range_t m_tab [4][$];
    bit     m_err;
    int     cur_var;

    always #5 clk = ~clk;

    discrete_values_table_writer dut (
        .in_clock                           (clk),
        .in_reset                           (rst),
        .in_load_begin                      (load_begin),
        .in_load_variable_index             (load_var),
        .in_load_valid                      (load_valid),
        .out_load_ready                     (load_ready),
        .in_load_start_value                (load_start),
        .in_load_end_value                  (load_end),
        .in_load_last                       (load_last),
        .out_load_done                      (load_done),
        .out_load_error                     (load_error),
        .in_read_variable_index             (read_var),
        .in_read_entry_index                (read_entry),
        .out_start                          (rd_start),
        .out_end                            (rd_end),
        .out_number_of_discrete_assignments (rd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_start(int v, int e);
        if (e < m_tab[v].size()) return m_tab[v][e].s;
        return 16'd0;
    endfunction

    function automatic logic [15:0] exp_end(int v, int e);
        if (e < m_tab[v].size()) return m_tab[v][e].e;
        return 16'd0;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 4; v++) m_tab[v].delete();
        m_err = 0;
    endtask

    task automatic do_read(input int v, input int e);
        read_var   = 2'(v);
        read_entry = 8'(e);
        @(negedge clk);
    endtask

    task automatic read_sweep();
        int e;
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 11; k++) begin
                e = (k == 10) ? int'($urandom_range(0, 255)) : k;
                do_read(v, e);
                check("rd_start", rd_start, exp_start(v, e));
                check("rd_end", rd_end, exp_end(v, e));
                check("rd_count", rd_count, m_tab[v].size());
            end
        end
    endtask

    task automatic begin_load(input int v);
        load_begin = 1'b1;
        load_var   = 2'(v);
        @(negedge clk);
        load_begin = 1'b0;
        load_var   = 2'($urandom_range(0, 3));
        m_tab[v].delete();
        m_err   = 0;
        cur_var = v;
        check("ready_in_load", load_ready, 1);
        check("error_cleared", load_error, 0);
    endtask

    task automatic send_beat(input logic [15:0] s, input logic [15:0] e, input bit last, input int gaps);
        int pre;
        for (int g = 0; g < gaps; g++) begin
            load_valid = 1'b0;
            load_start = 16'($urandom);
            load_end   = 16'($urandom);
            load_last  = 1'($urandom);
            load_begin = 1'($urandom);
            load_var   = 2'($urandom_range(0, 3));
            @(negedge clk);
            load_begin = 1'b0;
            check("gap_ready", load_ready, 1);
            check("gap_done", load_done, 0);
        end
        pre        = m_tab[cur_var].size();
        read_var   = 2'(cur_var);
        read_entry = 8'(pre);
        load_valid = 1'b1;
        load_start = s;
        load_end   = e;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("rd_count_prewrite", rd_count, pre);
        check("rd_start_prewrite", rd_start, 0);
        if (s > e || pre == 8) m_err = 1;
        else m_tab[cur_var].push_back('{s: s, e: e});
        check("load_error", load_error, m_err);
        if (last) begin
            check("done_pulse", load_done, 1);
            check("ready_in_done", load_ready, 0);
            @(negedge clk);
            check("done_one_cycle", load_done, 0);
            check("ready_idle", load_ready, 0);
        end else begin
            check("ready_mid", load_ready, 1);
            check("done_mid", load_done, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] s, e, t;
        rst        = 1'b1;
        load_begin = 1'b0;
        load_var   = 2'd0;
        load_valid = 1'b0;
        load_start = 16'd0;
        load_end   = 16'd0;
        load_last  = 1'b0;
        read_var   = 2'd0;
        read_entry = 8'd0;
        model_reset();
        #1;
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
        check("rst_count", rd_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_read(2, 0);
        check("init_start", rd_start, 0);
        check("init_end", rd_end, 0);
        check("init_count", rd_count, 0);

        begin_load(1);
        send_beat(16'd3, 16'd5, 0, 0);
        send_beat(16'd10, 16'd10, 0, 0);
        send_beat(16'd20, 16'd30, 1, 0);
        do_read(1, 1);
        check("v1_e1_start", rd_start, 16'd10);
        check("v1_e1_end", rd_end, 16'd10);
        check("v1_count", rd_count, 3);
        check("v1_error", load_error, 0);

        begin_load(0);
        send_beat(16'd7, 16'd4, 0, 0);
        send_beat(16'd1, 16'd2, 1, 0);
        check("v0_error", load_error, 1);
        do_read(0, 0);
        check("v0_count", rd_count, 1);
        check("v0_e0_start", rd_start, 16'd1);
        check("v0_e0_end", rd_end, 16'd2);

        begin_load(3);
        for (int i = 0; i < 9; i++) send_beat(16'(i), 16'(i), i == 8, 0);
        check("v3_error", load_error, 1);
        do_read(3, 7);
        check("v3_count", rd_count, 8);
        check("v3_e7_start", rd_start, 16'd7);
        check("v3_e7_end", rd_end, 16'd7);

        begin_load(2);
        for (int i = 0; i < 4; i++) send_beat(16'(100 + i), 16'(200 + i), i == 3, 2);
        read_sweep();

        begin_load(2);
        send_beat(16'd1, 16'd1, 0, 0);
        send_beat(16'd2, 16'd2, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", load_ready, 0);
        check("midrst_done", load_done, 0);
        check("midrst_start", rd_start, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", load_done, 0);
            check("idle_after_rst", load_ready, 0);
        end
        read_sweep();

        for (int l = 0; l < 25; l++) begin
            begin_load(int'($urandom_range(0, 3)));
            n = int'($urandom_range(1, 11));
            for (int i = 0; i < n; i++) begin
                s = 16'($urandom);
                e = 16'($urandom);
                if ($urandom_range(0, 3) != 0 && e < s) begin
                    t = s; s = e; e = t;
                end
                send_beat(s, e, i == n - 1, int'($urandom_range(0, 2)));
            end
            read_sweep();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
